// File: rtl/fb_read_port.sv
// fb_read_port: pixel read port for the colour-index framebuffer.
// Requests (x,y) are clipped, converted to a linear address, issued on a
// shared one-cycle-latency BRAM read port and answered in request order
// through a small first-word-fall-through response queue.
module fb_read_port #(
  parameter int CORDW  = 16,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 360,
  parameter int CIDXW  = 4,
  parameter int OUTQ   = 4,
  parameter int ADDRW  = $clog2(WIDTH*HEIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CORDW-1:0] req_x,
  input  logic [CORDW-1:0] req_y,
  input  logic             mem_busy,
  output logic             mem_re,
  output logic [ADDRW-1:0] mem_addr,
  input  logic [CIDXW-1:0] mem_rdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [CIDXW-1:0] resp_cidx,
  output logic             resp_clip
);

  localparam int PTRW = (OUTQ > 1) ? $clog2(OUTQ) : 1;
  localparam int CNTW = $clog2(OUTQ + 1);
  localparam logic signed [CORDW-1:0] WIDTH_S  = CORDW'(WIDTH);
  localparam logic signed [CORDW-1:0] HEIGHT_S = CORDW'(HEIGHT);

  // Queue pointer increment with wrap at the queue depth (depth need not be a power of two).
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    if (p == PTRW'(OUTQ - 1)) begin
      return {PTRW{1'b0}};
    end else begin
      return p + PTRW'(1);
    end
  endfunction

  // Stage registers
  logic                    en_r;
  logic                    a_valid_r, a_clip_r;
  logic signed [CORDW-1:0] a_x_r, a_y_r;
  logic                    b_valid_r, b_clip_r;
  logic [ADDRW-1:0]        b_addr_r;
  logic                    c_valid_r, c_clip_r;
  logic [ADDRW-1:0]        mem_addr_r;
  logic                    d_valid_r, d_clip_r;
  logic [CNTW-1:0]         out_cnt_r;

  // Response queue
  logic [CIDXW-1:0]        q_cidx_r [OUTQ];
  logic                    q_clip_r [OUTQ];
  logic [PTRW-1:0]         wptr_r, rptr_r;
  logic [CNTW-1:0]         q_cnt_r;
  logic                    resp_valid_r, resp_clip_r;
  logic [CIDXW-1:0]        resp_cidx_r;

  // Combinational control
  logic             req_clip_s, c_stall_s, c_free_s, b_free_s, a_free_s;
  logic             room_s, req_ready_s, accept_s, pop_s, push_s;
  logic [ADDRW-1:0] addr_s;
  logic [CIDXW-1:0] d_cidx_s, head_cidx_s;
  logic             head_clip_s;
  logic [PTRW-1:0]  rptr_n_s;
  logic [CNTW-1:0]  q_cnt_n_s, out_cnt_n_s;

  // Handshake, stall chain, clipping and address arithmetic.
  always_comb begin
    req_clip_s = req_x[CORDW-1] | ($signed(req_x) >= WIDTH_S) |
                 req_y[CORDW-1] | ($signed(req_y) >= HEIGHT_S);
    // Only a non-clipped request waiting on a busy BRAM port can hold C.
    c_stall_s   = c_valid_r & ~c_clip_r & mem_busy;
    c_free_s    = ~c_stall_s;
    b_free_s    = ~b_valid_r | c_free_s;
    a_free_s    = ~a_valid_r | b_free_s;
    pop_s       = resp_valid_r & resp_ready;
    // A pop in the same cycle frees a credit, so accept can proceed at full occupancy.
    room_s      = (out_cnt_r < CNTW'(OUTQ)) | pop_s;
    req_ready_s = en_r & a_free_s & room_s;
    accept_s    = req_valid & req_ready_s;
    addr_s      = ADDRW'(a_y_r) * ADDRW'(WIDTH) + ADDRW'(a_x_r);
    push_s      = d_valid_r;
    if (d_clip_r) begin
      d_cidx_s = {CIDXW{1'b0}};
    end else begin
      d_cidx_s = mem_rdata;
    end
  end

  // Next-state for the outstanding-credit counter and the queue head.
  always_comb begin
    case ({accept_s, pop_s})
      2'b10:   out_cnt_n_s = out_cnt_r + CNTW'(1);
      2'b01:   out_cnt_n_s = out_cnt_r - CNTW'(1);
      default: out_cnt_n_s = out_cnt_r;
    endcase
    case ({push_s, pop_s})
      2'b10:   q_cnt_n_s = q_cnt_r + CNTW'(1);
      2'b01:   q_cnt_n_s = q_cnt_r - CNTW'(1);
      default: q_cnt_n_s = q_cnt_r;
    endcase
    if (pop_s) begin
      rptr_n_s = ptr_inc(rptr_r);
    end else begin
      rptr_n_s = rptr_r;
    end
    // Bypass the write when the incoming entry becomes the new head.
    if (push_s && (wptr_r == rptr_n_s)) begin
      head_cidx_s = d_cidx_s;
      head_clip_s = d_clip_r;
    end else begin
      head_cidx_s = q_cidx_r[rptr_n_s];
      head_clip_s = q_clip_r[rptr_n_s];
    end
  end

  // Accept enable, credit counter and pipeline stages A..D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_r       <= 1'b0;
      out_cnt_r  <= {CNTW{1'b0}};
      a_valid_r  <= 1'b0;
      a_clip_r   <= 1'b0;
      a_x_r      <= {CORDW{1'b0}};
      a_y_r      <= {CORDW{1'b0}};
      b_valid_r  <= 1'b0;
      b_clip_r   <= 1'b0;
      b_addr_r   <= {ADDRW{1'b0}};
      c_valid_r  <= 1'b0;
      c_clip_r   <= 1'b0;
      mem_addr_r <= {ADDRW{1'b0}};
      d_valid_r  <= 1'b0;
      d_clip_r   <= 1'b0;
    end else begin
      en_r      <= 1'b1;
      out_cnt_r <= out_cnt_n_s;
      if (a_free_s) begin
        a_valid_r <= accept_s;
        if (accept_s) begin
          a_x_r    <= $signed(req_x);
          a_y_r    <= $signed(req_y);
          a_clip_r <= req_clip_s;
        end
      end
      if (b_free_s) begin
        b_valid_r <= a_valid_r;
        if (a_valid_r) begin
          b_clip_r <= a_clip_r;
          b_addr_r <= a_clip_r ? {ADDRW{1'b0}} : addr_s;
        end
      end
      if (c_free_s) begin
        c_valid_r <= b_valid_r;
        if (b_valid_r) begin
          c_clip_r   <= b_clip_r;
          mem_addr_r <= b_addr_r;
        end
      end
      // D follows C one cycle behind, aligned with the BRAM read data.
      d_valid_r <= c_valid_r & c_free_s;
      d_clip_r  <= c_clip_r;
    end
  end

  // Response queue storage, pointers and registered head outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUTQ; i++) begin
        q_cidx_r[i] <= {CIDXW{1'b0}};
        q_clip_r[i] <= 1'b0;
      end
      wptr_r       <= {PTRW{1'b0}};
      rptr_r       <= {PTRW{1'b0}};
      q_cnt_r      <= {CNTW{1'b0}};
      resp_valid_r <= 1'b0;
      resp_cidx_r  <= {CIDXW{1'b0}};
      resp_clip_r  <= 1'b0;
    end else begin
      if (push_s) begin
        q_cidx_r[wptr_r] <= d_cidx_s;
        q_clip_r[wptr_r] <= d_clip_r;
        wptr_r           <= ptr_inc(wptr_r);
      end
      rptr_r       <= rptr_n_s;
      q_cnt_r      <= q_cnt_n_s;
      resp_valid_r <= (q_cnt_n_s != {CNTW{1'b0}});
      // Outputs keep their last value while the queue is empty.
      if (q_cnt_n_s != {CNTW{1'b0}}) begin
        resp_cidx_r <= head_cidx_s;
        resp_clip_r <= head_clip_s;
      end
    end
  end

  assign req_ready  = req_ready_s;
  assign mem_re     = c_valid_r & ~c_clip_r & ~mem_busy;
  assign mem_addr   = mem_addr_r;
  assign resp_valid = resp_valid_r;
  assign resp_cidx  = resp_cidx_r;
  assign resp_clip  = resp_clip_r;

endmodule

// File: tb/tb_fb_read_port.sv
// Directed testbench for fb_read_port with a behavioural BRAM model.
module tb_fb_read_port;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_x, req_y;
  logic        mem_busy;
  logic        mem_re;
  logic [17:0] mem_addr;
  logic [3:0]  mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [3:0]  resp_cidx;
  logic        resp_clip;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  int busy_viol = 0;
  logic [17:0] re_q[$];
  logic [4:0]  rsp_q[$];

  fb_read_port dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .mem_busy(mem_busy), .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_cidx(resp_cidx), .resp_clip(resp_clip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer contents: address 0 preloaded with 9, others a fixed pattern.
  function automatic logic [3:0] mem_fn(input logic [17:0] a);
    if (a == 18'd0) return 4'h9;
    return a[3:0] ^ a[11:8] ^ 4'h5;
  endfunction

  // BRAM model with one cycle of read latency.
  always @(posedge clk) if (mem_re) mem_rdata <= mem_fn(mem_addr);

  // Monitors: issued reads, popped responses, accepts, reads issued while busy.
  always @(posedge clk) begin
    if (mem_re) re_q.push_back(mem_addr);
    if (mem_re && mem_busy) busy_viol++;
    if (resp_valid && resp_ready) rsp_q.push_back({resp_clip, resp_cidx});
    if (rst_n && req_valid && req_ready) acc_cnt++;
  end

  // Present one request and hold it until accepted (called #1 after a rising edge).
  task automatic send(input int x, input int y);
    int k;
    req_x = 16'(x); req_y = 16'(y); req_valid = 1'b1; k = 0;
    @(negedge clk);
    while (!req_ready && k < 100) begin @(negedge clk); k++; end
    checks++;
    if (!req_ready) begin
      failures++;
      $display("FAIL send_timeout x=%0d y=%0d req_ready=%0b required=1", x, y, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input string tag);
    int k;
    k = 0;
    while (rsp_q.size() < n && k < 300) begin @(posedge clk); k++; end
    checks++;
    if (rsp_q.size() < n) begin
      failures++;
      $display("FAIL %s_timeout responses=%0d required=%0d", tag, rsp_q.size(), n);
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; req_valid = 1'b0; req_x = 16'd0; req_y = 16'd0;
    mem_busy = 1'b0; resp_ready = 1'b1; mem_rdata = 4'h0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%0b exp=0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%0b exp=0", resp_valid); end
    checks++; if (resp_cidx !== 4'h0 || resp_clip !== 1'b0) begin failures++; $display("FAIL rst_resp_data got=%h/%0b exp=0/0", resp_cidx, resp_clip); end
    checks++; if (mem_re !== 1'b0 || mem_addr !== 18'd0) begin failures++; $display("FAIL rst_mem got=%0b/%0d exp=0/0", mem_re, mem_addr); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rel_req_ready_early got=%0b exp=0", req_ready); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rel_req_ready got=%0b exp=1", req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_latency;
    re_q.delete(); rsp_q.delete();
    req_x = 16'd0; req_y = 16'd0; req_valid = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL lat_ready got=%0b exp=1", req_ready); end
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_re !== 1'b0) begin failures++; $display("FAIL lat_re_c0 got=%0b exp=0", mem_re); end
    @(negedge clk);
    checks++; if (mem_re !== 1'b0) begin failures++; $display("FAIL lat_re_c1 got=%0b exp=0", mem_re); end
    @(negedge clk);
    checks++; if (mem_re !== 1'b1 || mem_addr !== 18'd0) begin failures++; $display("FAIL lat_re_c2 got=%0b/%0d exp=1/0", mem_re, mem_addr); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL lat_valid_c3 got=%0b exp=0", resp_valid); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_cidx !== 4'h9 || resp_clip !== 1'b0)
      begin failures++; $display("FAIL lat_resp_c4 got=%0b/%h/%0b exp=1/9/0", resp_valid, resp_cidx, resp_clip); end
    repeat (3) @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || resp_cidx !== 4'h9)
      begin failures++; $display("FAIL hold_last got=%0b/%h exp=0/9", resp_valid, resp_cidx); end
    @(posedge clk); #1;
  endtask

  task automatic test_addr;
    re_q.delete(); rsp_q.delete();
    send(639, 359);
    send(320, 180);
    wait_rsp(2, "addr");
    checks++; if (re_q.size() != 2) begin failures++; $display("FAIL addr_count got=%0d exp=2", re_q.size()); end
    else begin
      checks++; if (re_q[0] !== 18'd230399) begin failures++; $display("FAIL addr_max got=%0d exp=230399", re_q[0]); end
      checks++; if (re_q[1] !== 18'd115520) begin failures++; $display("FAIL addr_mid got=%0d exp=115520", re_q[1]); end
    end
    if (rsp_q.size() >= 2) begin
      checks++; if (rsp_q[0] !== {1'b0, mem_fn(18'd230399)}) begin failures++; $display("FAIL addr_rsp0 got=%h exp=%h", rsp_q[0], {1'b0, mem_fn(18'd230399)}); end
      checks++; if (rsp_q[1] !== {1'b0, mem_fn(18'd115520)}) begin failures++; $display("FAIL addr_rsp1 got=%h exp=%h", rsp_q[1], {1'b0, mem_fn(18'd115520)}); end
    end
  endtask

  task automatic test_clip;
    re_q.delete(); rsp_q.delete();
    send(-1, 5);
    send(640, 0);
    send(0, 360);
    wait_rsp(3, "clip");
    checks++; if (re_q.size() != 0) begin failures++; $display("FAIL clip_no_re got=%0d exp=0", re_q.size()); end
    checks++; if (rsp_q.size() != 3) begin failures++; $display("FAIL clip_count got=%0d exp=3", rsp_q.size()); end
    for (int i = 0; i < rsp_q.size(); i++) begin
      checks++;
      if (rsp_q[i] !== 5'h10) begin failures++; $display("FAIL clip_rsp%0d got=%h exp=10", i, rsp_q[i]); end
    end
  endtask

  task automatic test_busy_stream;
    logic [17:0] ea;
    re_q.delete(); rsp_q.delete(); busy_viol = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(i * 3 + 1, i + 2);
      end
      begin
        repeat (3) @(posedge clk);
        #1 mem_busy = 1'b1;
        repeat (5) @(posedge clk);
        #1 mem_busy = 1'b0;
      end
    join
    wait_rsp(8, "stream");
    checks++; if (rsp_q.size() != 8) begin failures++; $display("FAIL stream_count got=%0d exp=8", rsp_q.size()); end
    checks++; if (re_q.size() != 8) begin failures++; $display("FAIL stream_reads got=%0d exp=8", re_q.size()); end
    checks++; if (busy_viol != 0) begin failures++; $display("FAIL stream_re_busy got=%0d exp=0", busy_viol); end
    for (int i = 0; i < 8; i++) begin
      ea = 18'((i + 2) * 640 + i * 3 + 1);
      if (i < rsp_q.size()) begin
        checks++;
        if (rsp_q[i] !== {1'b0, mem_fn(ea)}) begin failures++; $display("FAIL stream_rsp%0d got=%h exp=%h", i, rsp_q[i], {1'b0, mem_fn(ea)}); end
      end
      if (i < re_q.size()) begin
        checks++;
        if (re_q[i] !== ea) begin failures++; $display("FAIL stream_addr%0d got=%0d exp=%0d", i, re_q[i], ea); end
      end
    end
  endtask

  task automatic test_backpressure;
    re_q.delete(); rsp_q.delete();
    resp_ready = 1'b0; acc_cnt = 0;
    req_x = 16'd10; req_y = 16'd1; req_valid = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++; if (acc_cnt != 4) begin failures++; $display("FAIL bp_accepts got=%0d exp=4", acc_cnt); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got=%0b exp=0", req_ready); end
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%0b exp=1", resp_valid); end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++; if (acc_cnt != 5) begin failures++; $display("FAIL bp_pop_accept got=%0d exp=5", acc_cnt); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_ready2 got=%0b exp=0", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0; resp_ready = 1'b1;
    wait_rsp(5, "bp");
    checks++; if (rsp_q.size() != 5) begin failures++; $display("FAIL bp_rsp_count got=%0d exp=5", rsp_q.size()); end
    for (int i = 0; i < rsp_q.size(); i++) begin
      checks++;
      if (rsp_q[i] !== {1'b0, mem_fn(18'd650)}) begin failures++; $display("FAIL bp_rsp%0d got=%h exp=%h", i, rsp_q[i], {1'b0, mem_fn(18'd650)}); end
    end
  endtask

  task automatic test_reset_mid;
    int k;
    re_q.delete(); rsp_q.delete();
    resp_ready = 1'b1;
    send(5, 5);
    send(6, 5);
    send(7, 5);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_re !== 1'b0) begin failures++; $display("FAIL mid_re got=%0b exp=0", mem_re); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%0b exp=0", resp_valid); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%0b exp=0", req_ready); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (rsp_q.size() != 0) begin failures++; $display("FAIL mid_discard got=%0d exp=0", rsp_q.size()); end
    k = rsp_q.size();
    send(0, 0);
    wait_rsp(k + 1, "mid_new");
    if (rsp_q.size() > k) begin
      checks++;
      if (rsp_q[k] !== 5'h09) begin failures++; $display("FAIL mid_new_rsp got=%h exp=09", rsp_q[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_addr();
    test_clip();
    test_busy_stream();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
